cruise_ctrl_param: RTL and testbench

Second-generation cruise-control core: a parametrised speed/set-point controller. It models vehicle speed from driver pedal and stalk inputs, and engages, holds, adjusts, suspends and resumes a cruise set-point. Compared with the first-generation controller it adds configurable width, step sizes and update rate. It also adds saturating arithmetic, overshoot-free regulation, a retained set-point across suspend, and an explicit set-point-valid flag. It sits between the driver-input debouncers and the speed display/actuator logic.

---
 rtl/cruise_ctrl_param.sv | 184 ++++++++++++++++++
 tb/tb_cruise_ctrl_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cruise_ctrl_param.sv
// Parametrised cruise-control core: models vehicle speed from driver inputs and
// engages, holds, adjusts, suspends and resumes a saturating cruise set-point.
module cruise_ctrl_param #(
  parameter int unsigned W          = 8,
  parameter int unsigned MIN_SET    = 46,
  parameter int unsigned MAX_SPEED  = (1 << W) - 1,
  parameter int unsigned ACC_STEP   = 1,
  parameter int unsigned COAST_STEP = 1,
  parameter int unsigned DRAG_STEP  = 1,
  parameter int unsigned BRAKE_STEP = 2,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         throttle,
  input  logic         set,
  input  logic         accel,
  input  logic         coast,
  input  logic         cancel,
  input  logic         resume,
  input  logic         brake,
  output logic [W-1:0] speed,
  output logic [W-1:0] cruisespeed,
  output logic         cruisectrl,
  output logic         sp_valid,
  output logic [1:0]   state_o
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [W-1:0] MAXV  = W'(MAX_SPEED);
  localparam logic [W-1:0] MINS  = W'(MIN_SET);
  localparam logic [W-1:0] ACC   = W'(ACC_STEP);
  localparam logic [W-1:0] COAST = W'(COAST_STEP);
  localparam logic [W-1:0] DRAG  = W'(DRAG_STEP);
  localparam logic [W-1:0] BRAKE = W'(BRAKE_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    CRUISE = 2'd2
  } state_e;

  state_e             state_q;
  logic [W-1:0]       speed_q;
  logic [W-1:0]       cruisespeed_q;
  logic               cruisectrl_q;
  logic               sp_valid_q;
  logic [DIV_W-1:0]   div_cnt_q;

  logic               tick;
  logic [W-1:0]       manual_spd;
  logic               manual_idle;
  logic [W-1:0]       reg_spd;
  logic [W-1:0]       coast_cs;
  logic [W-1:0]       diff;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] s);
    logic [W:0] sum;
    sum = {1'b0, x} + {1'b0, s};
    return (sum > {1'b0, MAXV}) ? MAXV : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] x, input logic [W-1:0] s);
    return (x > s) ? (x - s) : '0;
  endfunction

  assign tick = (div_cnt_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    manual_spd  = '0;
    manual_idle = 1'b0;
    reg_spd     = speed_q;
    coast_cs    = '0;
    diff        = '0;

    if (brake) begin
      manual_spd = sat_sub(speed_q, BRAKE);
    end else if (throttle) begin
      manual_spd = sat_add(speed_q, ACC);
    end else begin
      manual_spd = sat_sub(speed_q, DRAG);
    end
    // Only a slowing rule (brake or drag) may drop the car back to IDLE.
    manual_idle = (brake || !throttle) && (manual_spd == '0);

    // Regulation steps are clipped to the gap so the set-point is never overshot.
    if (speed_q > cruisespeed_q) begin
      diff    = speed_q - cruisespeed_q;
      reg_spd = speed_q - ((diff < DRAG) ? diff : DRAG);
    end else if (speed_q < cruisespeed_q) begin
      diff    = cruisespeed_q - speed_q;
      reg_spd = speed_q + ((diff < ACC) ? diff : ACC);
    end

    coast_cs = sat_sub(cruisespeed_q, COAST);
    if (coast_cs < MINS) begin
      coast_cs = MINS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      speed_q       <= '0;
      cruisespeed_q <= '0;
      cruisectrl_q  <= 1'b0;
      sp_valid_q    <= 1'b0;
      div_cnt_q     <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) begin
        case (state_q)
          IDLE: begin
            speed_q <= '0;
            if (throttle) begin
              state_q <= MANUAL;
              speed_q <= ACC;
            end else if (cancel) begin
              sp_valid_q    <= 1'b0;
              cruisespeed_q <= '0;
            end
          end
          MANUAL: begin
            if (cancel) begin
              sp_valid_q    <= 1'b0;
              cruisespeed_q <= '0;
              speed_q       <= manual_spd;
              if (manual_idle) state_q <= IDLE;
            end else if (resume && sp_valid_q && !brake) begin
              state_q      <= CRUISE;
              cruisectrl_q <= 1'b1;
              speed_q      <= reg_spd;
            end else if (set && !brake && (speed_q >= MINS)) begin
              state_q       <= CRUISE;
              cruisectrl_q  <= 1'b1;
              cruisespeed_q <= speed_q;
              sp_valid_q    <= 1'b1;
            end else begin
              speed_q <= manual_spd;
              if (manual_idle) state_q <= IDLE;
            end
          end
          CRUISE: begin
            if (brake) begin
              state_q      <= MANUAL;
              cruisectrl_q <= 1'b0;
              speed_q      <= sat_sub(speed_q, BRAKE);
            end else if (cancel) begin
              state_q      <= MANUAL;
              cruisectrl_q <= 1'b0;
              speed_q      <= sat_sub(speed_q, DRAG);
            end else if (set && (speed_q >= MINS)) begin
              cruisespeed_q <= speed_q;
            end else if (accel) begin
              cruisespeed_q <= sat_add(cruisespeed_q, ACC);
              speed_q       <= sat_add(speed_q, ACC);
            end else if (coast) begin
              cruisespeed_q <= coast_cs;
              speed_q       <= sat_sub(speed_q, COAST);
            end else if (throttle) begin
              speed_q <= sat_add(speed_q, ACC);
            end else begin
              speed_q <= reg_spd;
            end
          end
          default: begin
            state_q      <= IDLE;
            speed_q      <= '0;
            cruisectrl_q <= 1'b0;
            sp_valid_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign speed       = speed_q;
  assign cruisespeed = cruisespeed_q;
  assign cruisectrl  = cruisectrl_q;
  assign sp_valid    = sp_valid_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cruise_ctrl_param.sv
// Bench for cruise_ctrl_param: a default instance and a TICK_DIV=4 instance share
// stimulus; a behavioural model feeds per-cycle expectations into scoreboard queues.
module tb_cruise_ctrl_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic throttle = 1'b0, set = 1'b0, accel = 1'b0, coast = 1'b0;
  logic cancel = 1'b0, resume = 1'b0, brake = 1'b0;

  logic [7:0] speed0, cs0, speed1, cs1;
  logic       cc0, spv0, cc1, spv1;
  logic [1:0] st0, st1;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] TH  = 7'b1000000;
  localparam logic [6:0] SE  = 7'b0100000;
  localparam logic [6:0] AC  = 7'b0010000;
  localparam logic [6:0] CO  = 7'b0001000;
  localparam logic [6:0] CA  = 7'b0000100;
  localparam logic [6:0] RE  = 7'b0000010;
  localparam logic [6:0] BR  = 7'b0000001;
  localparam logic [6:0] NONE = 7'b0000000;

  cruise_ctrl_param dut0 (
    .clk(clk), .reset(reset), .throttle(throttle), .set(set), .accel(accel),
    .coast(coast), .cancel(cancel), .resume(resume), .brake(brake),
    .speed(speed0), .cruisespeed(cs0), .cruisectrl(cc0), .sp_valid(spv0), .state_o(st0)
  );

  cruise_ctrl_param #(.TICK_DIV(4)) dut1 (
    .clk(clk), .reset(reset), .throttle(throttle), .set(set), .accel(accel),
    .coast(coast), .cancel(cancel), .resume(resume), .brake(brake),
    .speed(speed1), .cruisespeed(cs1), .cruisectrl(cc1), .sp_valid(spv1), .state_o(st1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] spd;
    logic [7:0] cs;
    logic       cc;
    logic       spv;
    logic [1:0] st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  int m_spd[2], m_cs[2], m_st[2], m_spv[2], m_div[2];
  int tdiv[2] = '{1, 4};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int addv(input int x, input int s);
    return (x + s > 255) ? 255 : x + s;
  endfunction

  function automatic int subv(input int x, input int s);
    return (x - s < 0) ? 0 : x - s;
  endfunction

  task automatic manual_rule(input int k, input bit th, input bit br);
    if (br) m_spd[k] = subv(m_spd[k], 2);
    else if (th) m_spd[k] = addv(m_spd[k], 1);
    else m_spd[k] = subv(m_spd[k], 1);
    if ((br || !th) && m_spd[k] == 0) m_st[k] = 0;
  endtask

  task automatic regulate(input int k);
    int gap;
    if (m_spd[k] > m_cs[k]) begin
      gap = m_spd[k] - m_cs[k];
      m_spd[k] -= (gap < 1) ? gap : 1;
    end else if (m_spd[k] < m_cs[k]) begin
      gap = m_cs[k] - m_spd[k];
      m_spd[k] += (gap < 1) ? gap : 1;
    end
  endtask

  task automatic model_clk(input int k, input logic [6:0] in, input bit rst);
    bit th, se, ac, co, ca, re, br, tk;
    {th, se, ac, co, ca, re, br} = in;
    if (rst) begin
      m_spd[k] = 0; m_cs[k] = 0; m_st[k] = 0; m_spv[k] = 0; m_div[k] = 0;
      return;
    end
    tk = (m_div[k] == tdiv[k] - 1);
    m_div[k] = tk ? 0 : m_div[k] + 1;
    if (!tk) return;
    case (m_st[k])
      0: begin
        m_spd[k] = 0;
        if (th) begin m_st[k] = 1; m_spd[k] = 1; end
        else if (ca) begin m_spv[k] = 0; m_cs[k] = 0; end
      end
      1: begin
        if (ca) begin
          m_spv[k] = 0; m_cs[k] = 0;
          manual_rule(k, th, br);
        end else if (re && m_spv[k] != 0 && !br) begin
          m_st[k] = 2;
          regulate(k);
        end else if (se && !br && m_spd[k] >= 46) begin
          m_st[k] = 2; m_cs[k] = m_spd[k]; m_spv[k] = 1;
        end else begin
          manual_rule(k, th, br);
        end
      end
      default: begin
        if (br) begin m_st[k] = 1; m_spd[k] = subv(m_spd[k], 2); end
        else if (ca) begin m_st[k] = 1; m_spd[k] = subv(m_spd[k], 1); end
        else if (se && m_spd[k] >= 46) m_cs[k] = m_spd[k];
        else if (ac) begin m_cs[k] = addv(m_cs[k], 1); m_spd[k] = addv(m_spd[k], 1); end
        else if (co) begin
          m_cs[k] = (m_cs[k] - 1 < 46) ? 46 : m_cs[k] - 1;
          m_spd[k] = subv(m_spd[k], 1);
        end
        else if (th) m_spd[k] = addv(m_spd[k], 1);
        else regulate(k);
      end
    endcase
  endtask

  function automatic exp_t mk(input int k);
    exp_t e;
    e.spd = 8'(m_spd[k]);
    e.cs  = 8'(m_cs[k]);
    e.cc  = (m_st[k] == 2);
    e.spv = (m_spv[k] != 0);
    e.st  = 2'(m_st[k]);
    return e;
  endfunction

  // Drive at a falling edge, queue the post-edge expectation, return at the next falling edge.
  task automatic step(input logic [6:0] in, input bit rst = 1'b0);
    {throttle, set, accel, coast, cancel, resume, brake} = in;
    reset = rst;
    for (int k = 0; k < 2; k++) model_clk(k, in, rst);
    q0.push_back(mk(0));
    q1.push_back(mk(1));
    @(negedge clk);
  endtask

  task automatic run(input logic [6:0] in, input int n);
    for (int i = 0; i < n; i++) step(in);
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      mon_e = q0.pop_front();
      check("speed0", int'(speed0), int'(mon_e.spd));
      check("cspeed0", int'(cs0), int'(mon_e.cs));
      check("cctrl0", int'(cc0), int'(mon_e.cc));
      check("spvalid0", int'(spv0), int'(mon_e.spv));
      check("state0", int'(st0), int'(mon_e.st));
    end
    if (q1.size() > 0) begin
      mon_e = q1.pop_front();
      check("speed1", int'(speed1), int'(mon_e.spd));
      check("cspeed1", int'(cs1), int'(mon_e.cs));
      check("cctrl1", int'(cc1), int'(mon_e.cc));
      check("spvalid1", int'(spv1), int'(mon_e.spv));
      check("state1", int'(st1), int'(mon_e.st));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rin;
    @(negedge clk);
    step(NONE, 1'b1);
    step(NONE, 1'b1);
    check("rst_speed", int'(speed0), 0);
    check("rst_state", int'(st0), 0);
    check("rst_cs", int'(cs0), 0);
    check("rst_spv", int'(spv0), 0);
    check("rst_cc", int'(cc0), 0);

    // Engage at defaults
    run(TH, 46);
    check("eng_speed", int'(speed0), 46);
    check("eng_state_pre", int'(st0), 1);
    step(SE);
    check("eng_state", int'(st0), 2);
    check("eng_cc", int'(cc0), 1);
    check("eng_cs", int'(cs0), 46);
    check("eng_spv", int'(spv0), 1);
    check("eng_speed_hold", int'(speed0), 46);

    // Override and regulate
    run(TH, 5);
    check("ovr_peak", int'(speed0), 51);
    run(NONE, 5);
    check("ovr_back", int'(speed0), 46);
    run(NONE, 3);
    check("ovr_hold", int'(speed0), 46);
    check("ovr_cs", int'(cs0), 46);

    // Accel and coast floor
    run(AC, 3);
    check("acc_cs", int'(cs0), 49);
    check("acc_speed", int'(speed0), 49);
    run(CO, 10);
    check("cst_cs", int'(cs0), 46);
    check("cst_speed", int'(speed0), 39);
    run(NONE, 6);
    check("rec_6", int'(speed0), 45);
    step(NONE);
    check("rec_7", int'(speed0), 46);
    run(NONE, 2);
    check("rec_hold", int'(speed0), 46);

    // Brake and resume
    step(BR);
    check("brk1_speed", int'(speed0), 44);
    check("brk1_state", int'(st0), 1);
    check("brk1_cc", int'(cc0), 0);
    step(BR);
    check("brk2_speed", int'(speed0), 42);
    check("brk2_cs", int'(cs0), 46);
    check("brk2_spv", int'(spv0), 1);
    step(RE);
    check("res_state", int'(st0), 2);
    check("res_speed", int'(speed0), 43);
    run(NONE, 3);
    check("res_climb", int'(speed0), 46);

    // Cancel beats resume
    run(BR, 2);
    step(CA | RE);
    check("canres_spv", int'(spv0), 0);
    check("canres_state", int'(st0), 1);
    check("canres_speed", int'(speed0), 41);

    // Set rejected below MIN_SET
    step(NONE, 1'b1);
    run(TH, 45);
    step(SE);
    check("lowset_state", int'(st0), 1);
    check("lowset_speed", int'(speed0), 44);

    // Saturation at the top
    step(NONE, 1'b1);
    run(TH, 254);
    check("sat_254", int'(speed0), 254);
    step(TH);
    check("sat_255", int'(speed0), 255);
    run(TH, 3);
    check("sat_hold", int'(speed0), 255);

    // Brake at speed 1 floors at 0 and returns to IDLE
    step(NONE, 1'b1);
    step(TH);
    check("low_speed", int'(speed0), 1);
    step(BR);
    check("low_brake_speed", int'(speed0), 0);
    check("low_brake_state", int'(st0), 0);

    // Randomised mixed inputs, checked against the model
    step(NONE, 1'b1);
    for (int i = 0; i < 600; i++) begin
      rin[6] = ($urandom_range(0, 9) < 6);
      rin[5] = ($urandom_range(0, 9) == 0);
      rin[4] = ($urandom_range(0, 9) == 0);
      rin[3] = ($urandom_range(0, 9) == 0);
      rin[2] = ($urandom_range(0, 39) == 0);
      rin[1] = ($urandom_range(0, 9) == 0);
      rin[0] = ($urandom_range(0, 24) == 0);
      step(rin);
    end

    // TICK_DIV=4 instance: update rate and reset mid-CRUISE
    step(NONE, 1'b1);
    run(TH, 3);
    check("div_pre", int'(speed1), 0);
    step(TH);
    check("div_first", int'(speed1), 1);
    run(TH, 180);
    check("div_46", int'(speed1), 46);
    run(SE, 4);
    check("div_cruise", int'(st1), 2);
    check("div_cs", int'(cs1), 46);
    step(TH, 1'b1);
    check("div_rst_speed", int'(speed1), 0);
    check("div_rst_state", int'(st1), 0);
    check("div_rst_cc", int'(cc1), 0);
    check("div_rst_spv", int'(spv1), 0);
    run(TH, 3);
    check("div_rel_pre", int'(speed1), 0);
    step(TH);
    check("div_rel_tick", int'(speed1), 1);
    run(NONE, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
